data_mem_resp: RTL and testbench

DATA_MEM_RESP -- requirements
Module: data_mem_resp

---
 rtl/type_pkg.sv | 27 ++
 rtl/mem_align.sv | 53 +++++
 rtl/data_mem_resp.sv | 154 +++++++++++++++
 tb/tb_data_mem_resp.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/type_pkg.sv
// Shared types for the data memory responder: access-size codes, FSM states
// and the alignment rule used by both the datapath and the aligner.
package type_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;  // behaves as word
  localparam int         IDX_ZEXT  = 2;      // index bit selecting zero-extension

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic is_misaligned(input logic [2:0] index, input logic [1:0] addr_lo);
    logic mis;
    case (index[1:0])
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = addr_lo[0];
      default:   mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Lane steering for the data memory: store byte enables / data replication
// and load lane extraction with sign or zero extension.
module mem_align
  import type_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  index,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        misaligned
);

  logic [7:0]  lane8;
  logic [15:0] lane16;
  logic        sext;

  assign lane8  = rword[{addr_lo, 3'b000} +: 8];
  assign lane16 = addr_lo[1] ? rword[31:16] : rword[15:0];
  assign sext   = ~index[IDX_ZEXT];

  always_comb begin
    misaligned = is_misaligned(index, addr_lo);
    byte_en    = 4'b0000;
    wword      = wdata;
    rdata      = 32'd0;
    case (index[1:0])
      SIZE_BYTE: begin
        byte_en = 4'b0001 << addr_lo;
        wword   = {4{wdata[7:0]}};
        rdata   = {{24{sext & lane8[7]}}, lane8};
      end
      SIZE_HALF: begin
        byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword   = {2{wdata[15:0]}};
        rdata   = {{16{sext & lane16[15]}}, lane16};
      end
      default: begin
        byte_en = 4'b1111;
        wword   = wdata;
        rdata   = rword;
      end
    endcase
    // a misaligned access neither writes nor returns data
    if (misaligned) begin
      byte_en = 4'b0000;
      rdata   = 32'd0;
    end
  end

endmodule

// File: rtl/data_mem_resp.sv
// Data memory with a fixed-latency request/response handshake for the
// EX/MEM stage: byte/half/word loads and stores, misalignment reporting.
module data_mem_resp
  import type_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_raddr_i,
  input  logic [31:0] mem_waddr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [2:0]  r_index_i,
  input  logic [2:0]  w_index_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        misalign_o
);

  localparam int         AW       = $clog2(DEPTH);
  localparam int         AB       = AW + 2;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t          state, state_next;
  logic [3:0]      cnt;
  logic            accept, enter_resp;

  logic            we_q;
  logic [AB-1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [2:0]      index_q;

  logic            op_we;
  logic [AB-1:0]   op_addr;
  logic [31:0]     op_wdata;
  logic [2:0]      op_index;
  logic [AW-1:0]   word_idx;

  logic [31:0]     mem [DEPTH];
  logic [31:0]     rword, wword, load_data;
  logic [3:0]      byte_en;
  logic            misaligned;
  logic [31:0]     rdata_q;
  logic            mis_q;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^{mem_raddr_i[31:AB], mem_waddr_i[31:AB]};

  assign accept     = (state == ST_IDLE) && mem_req_i;
  assign enter_resp = (state_next == ST_RESP);

  // With WAIT_CYCLES=0 the access happens on the accept edge itself, so the
  // datapath looks at live inputs in IDLE and at the latched request otherwise.
  always_comb begin
    if (state == ST_IDLE) begin
      op_we    = mem_we_i;
      op_addr  = mem_we_i ? mem_waddr_i[AB-1:0] : mem_raddr_i[AB-1:0];
      op_wdata = mem_wdata_i;
      op_index = mem_we_i ? w_index_i : r_index_i;
    end else begin
      op_we    = we_q;
      op_addr  = addr_q;
      op_wdata = wdata_q;
      op_index = index_q;
    end
  end

  assign word_idx = op_addr[AB-1:2];
  assign rword    = mem[word_idx];

  mem_align u_align (
    .addr_lo    (op_addr[1:0]),
    .index      (op_index),
    .wdata      (op_wdata),
    .rword      (rword),
    .byte_en    (byte_en),
    .wword      (wword),
    .rdata      (load_data),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      if (accept)
        cnt <= CNT_INIT;
      else if (state == ST_BUSY && cnt != 4'd0)
        cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = (WAIT_CYCLES == 0) ? ST_RESP : ST_BUSY;
      ST_BUSY: if (cnt == 4'd0) state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    stall_o       = 1'b0;
    rdata_valid_o = 1'b0;
    misalign_o    = 1'b0;
    case (state)
      ST_IDLE: stall_o = mem_req_i;
      ST_BUSY: stall_o = 1'b1;
      ST_RESP: begin
        rdata_valid_o = 1'b1;
        misalign_o    = mis_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= mem_we_i;
      addr_q  <= mem_we_i ? mem_waddr_i[AB-1:0] : mem_raddr_i[AB-1:0];
      wdata_q <= mem_wdata_i;
      index_q <= mem_we_i ? w_index_i : r_index_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= 32'd0;
      mis_q   <= 1'b0;
    end else if (enter_resp) begin
      rdata_q <= op_we ? 32'd0 : load_data;
      mis_q   <= misaligned;
    end
  end

  assign rdata_o = rdata_q;

  // rst_n gating keeps a store that is aborted by reset from landing
  always_ff @(posedge clk) begin
    if (rst_n && enter_resp && op_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench: one instance with a busy cycle, one with zero wait,
// scoreboard queues fed by a byte-level reference model.
module tb_data_mem_resp;

  logic        clk, rst_n, req1, req0, we;
  logic [31:0] raddr, waddr, wdata;
  logic [2:0]  ridx, widx;
  logic        stall1, valid1, mis1, stall0, valid0, mis0;
  logic [31:0] rdata1, rdata0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        mis;
  } exp_t;

  exp_t        q1[$];
  exp_t        q0[$];
  logic [31:0] mdl1 [1024];
  logic [31:0] mdl0 [1024];
  int          n_checks = 0;
  int          n_fail   = 0;

  logic        b2b_w   [8];
  logic [31:0] b2b_a   [8];
  logic [31:0] b2b_d   [8];
  logic [2:0]  b2b_idx [8];

  data_mem_resp #(.DEPTH(1024), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .mem_req_i(req1), .mem_we_i(we),
    .mem_raddr_i(raddr), .mem_waddr_i(waddr), .mem_wdata_i(wdata),
    .r_index_i(ridx), .w_index_i(widx), .stall_o(stall1), .rdata_o(rdata1),
    .rdata_valid_o(valid1), .misalign_o(mis1)
  );

  data_mem_resp #(.DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .mem_req_i(req0), .mem_we_i(we),
    .mem_raddr_i(raddr), .mem_waddr_i(waddr), .mem_wdata_i(wdata),
    .r_index_i(ridx), .w_index_i(widx), .stall_o(stall0), .rdata_o(rdata0),
    .rdata_valid_o(valid0), .misalign_o(mis0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Byte-array reference model; sel picks which instance's memory image.
  function automatic exp_t model(input bit sel, input logic w, input logic [31:0] a,
                                 input logic [31:0] d, input logic [2:0] idx);
    exp_t       e;
    int         wi;
    logic [7:0] b [4];
    logic [31:0] word;
    int         lo;
    wi   = int'(a[11:2]);
    lo   = int'(a[1:0]);
    word = sel ? mdl0[wi] : mdl1[wi];
    for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
    e.rdata = 32'd0;
    e.mis   = (idx[1:0] == 2'b01) ? a[0] : ((idx[1:0] == 2'b00) ? 1'b0 : (a[1:0] != 2'b00));
    if (!e.mis) begin
      if (w) begin
        if (idx[1:0] == 2'b00) b[lo] = d[7:0];
        else if (idx[1:0] == 2'b01) begin b[lo] = d[7:0]; b[lo+1] = d[15:8]; end
        else for (int i = 0; i < 4; i++) b[i] = d[8*i +: 8];
        word = {b[3], b[2], b[1], b[0]};
        if (sel) mdl0[wi] = word; else mdl1[wi] = word;
      end else if (idx[1:0] == 2'b00) begin
        e.rdata = idx[2] ? {24'd0, b[lo]} : {{24{b[lo][7]}}, b[lo]};
      end else if (idx[1:0] == 2'b01) begin
        e.rdata = idx[2] ? {16'd0, b[lo+1], b[lo]} : {{16{b[lo+1][7]}}, b[lo+1], b[lo]};
      end else begin
        e.rdata = word;
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && valid1 === 1'b1) begin
      n_checks++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL sb1_unexpected: response rdata=%h with nothing pending", rdata1);
      end else begin
        e = q1.pop_front();
        if (rdata1 !== e.rdata || mis1 !== e.mis) begin
          n_fail++;
          $display("FAIL sb1_resp: got rdata=%h mis=%b, expected rdata=%h mis=%b", rdata1, mis1, e.rdata, e.mis);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && valid0 === 1'b1) begin
      n_checks++;
      if (q0.size() == 0) begin
        n_fail++;
        $display("FAIL sb0_unexpected: response rdata=%h with nothing pending", rdata0);
      end else begin
        e = q0.pop_front();
        if (rdata0 !== e.rdata || mis0 !== e.mis) begin
          n_fail++;
          $display("FAIL sb0_resp: got rdata=%h mis=%b, expected rdata=%h mis=%b", rdata0, mis0, e.rdata, e.mis);
        end
      end
    end
  end

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] idx);
    we    = w;
    wdata = w ? d : ~d;
    if (w) begin waddr = a; raddr = ~a; widx = idx; ridx = ~idx; end
    else   begin raddr = a; waddr = ~a; ridx = idx; widx = ~idx; end
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] idx,
                      output int lat, output int stalls, output logic [31:0] rd, output logic ms);
    @(posedge clk); #1;
    q1.push_back(model(1'b0, w, a, d, idx));
    drive(w, a, d, idx);
    req1   = 1'b1;
    lat    = -1;
    stalls = 0;
    rd     = 'x;
    ms     = 'x;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (stall1) stalls++;
      if (valid1) begin lat = c; rd = rdata1; ms = mis1; break; end
    end
    req1 = 1'b0;
    if (lat < 0) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: no response within 20 cycles for addr=%h", a);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++; if (stall1 !== 1'b0)   begin n_fail++; $display("FAIL rst_stall: got %b want 0", stall1); end
    n_checks++; if (valid1 !== 1'b0)   begin n_fail++; $display("FAIL rst_valid: got %b want 0", valid1); end
    n_checks++; if (mis1 !== 1'b0)     begin n_fail++; $display("FAIL rst_mis: got %b want 0", mis1); end
    n_checks++; if (rdata1 !== 32'd0)  begin n_fail++; $display("FAIL rst_rdata: got %h want 0", rdata1); end
    n_checks++; if (valid0 !== 1'b0)   begin n_fail++; $display("FAIL rst_valid0: got %b want 0", valid0); end
    n_checks++; if (rdata0 !== 32'd0)  begin n_fail++; $display("FAIL rst_rdata0: got %h want 0", rdata0); end
  endtask

  task automatic test_word;
    int lat, st; logic [31:0] rd; logic ms;
    send(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, lat, st, rd, ms);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL st_word_latency: got %0d want 2", lat); end
    n_checks++; if (st !== 2)  begin n_fail++; $display("FAIL st_word_stall: got %0d want 2", st); end
    n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL st_word_rdata: got %h want 0", rd); end
    send(1'b0, 32'h10, 32'h0, 3'b010, lat, st, rd, ms);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL ld_word_latency: got %0d want 2", lat); end
    n_checks++; if (st !== 2)  begin n_fail++; $display("FAIL ld_word_stall: got %0d want 2", st); end
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ld_word_data: got %h want deadbeef", rd); end
  endtask

  task automatic test_byte_half;
    int lat, st; logic [31:0] rd; logic ms;
    send(1'b1, 32'h13, 32'h00000080, 3'b000, lat, st, rd, ms);
    send(1'b0, 32'h13, 32'h0, 3'b000, lat, st, rd, ms);
    n_checks++; if (rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL ld_byte_signed: got %h want ffffff80", rd); end
    send(1'b0, 32'h13, 32'h0, 3'b100, lat, st, rd, ms);
    n_checks++; if (rd !== 32'h00000080) begin n_fail++; $display("FAIL ld_byte_unsigned: got %h want 00000080", rd); end
    send(1'b0, 32'h10, 32'h0, 3'b010, lat, st, rd, ms);
    n_checks++; if (rd !== 32'h80ADBEEF) begin n_fail++; $display("FAIL ld_word_after_byte: got %h want 80adbeef", rd); end
    send(1'b0, 32'h12, 32'h0, 3'b001, lat, st, rd, ms);
    n_checks++; if (rd !== 32'hFFFF80AD) begin n_fail++; $display("FAIL ld_half_signed: got %h want ffff80ad", rd); end
    send(1'b0, 32'h10, 32'h0, 3'b101, lat, st, rd, ms);
    n_checks++; if (rd !== 32'h0000BEEF) begin n_fail++; $display("FAIL ld_half_unsigned: got %h want 0000beef", rd); end
  endtask

  task automatic test_misalign;
    int lat, st; logic [31:0] rd; logic ms;
    send(1'b0, 32'h11, 32'h0, 3'b001, lat, st, rd, ms);
    n_checks++; if (ms !== 1'b1)   begin n_fail++; $display("FAIL mis_half_flag: got %b want 1", ms); end
    n_checks++; if (rd !== 32'd0)  begin n_fail++; $display("FAIL mis_half_data: got %h want 0", rd); end
    send(1'b1, 32'h12, 32'hCAFEF00D, 3'b010, lat, st, rd, ms);
    n_checks++; if (ms !== 1'b1)   begin n_fail++; $display("FAIL mis_store_flag: got %b want 1", ms); end
    send(1'b0, 32'h10, 32'h0, 3'b010, lat, st, rd, ms);
    n_checks++; if (rd !== 32'h80ADBEEF) begin n_fail++; $display("FAIL mis_store_nowrite: got %h want 80adbeef", rd); end
    n_checks++; if (ms !== 1'b0)   begin n_fail++; $display("FAIL aligned_flag: got %b want 0", ms); end
  endtask

  task automatic test_wrap;
    int lat, st; logic [31:0] rd; logic ms;
    send(1'b1, 32'h1000, 32'h12345678, 3'b010, lat, st, rd, ms);
    send(1'b0, 32'h0, 32'h0, 3'b010, lat, st, rd, ms);
    n_checks++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL wrap: got %h want 12345678", rd); end
  endtask

  task automatic test_reset_abort;
    int lat, st; logic [31:0] rd; logic ms;
    send(1'b1, 32'h20, 32'hA5A5A5A5, 3'b010, lat, st, rd, ms);
    send(1'b0, 32'h20, 32'h0, 3'b010, lat, st, rd, ms);
    n_checks++; if (rd !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL abort_pre: got %h want a5a5a5a5", rd); end
    // store left out of the model: reset must keep it from landing
    @(posedge clk); #1;
    drive(1'b1, 32'h20, 32'h5A5A5A5A, 3'b010);
    req1 = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (stall1 !== 1'b1) begin n_fail++; $display("FAIL abort_busy: stall got %b want 1", stall1); end
    rst_n = 1'b0;
    req1  = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (rdata1 !== 32'd0) begin n_fail++; $display("FAIL abort_rdata: got %h want 0", rdata1); end
    n_checks++; if (valid1 !== 1'b0)  begin n_fail++; $display("FAIL abort_valid: got %b want 0", valid1); end
    n_checks++; if (stall1 !== 1'b0)  begin n_fail++; $display("FAIL abort_stall: got %b want 0", stall1); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(1'b0, 32'h20, 32'h0, 3'b010, lat, st, rd, ms);
    n_checks++; if (rd !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL abort_nowrite: got %h want a5a5a5a5", rd); end
  endtask

  task automatic drive_op0(input int k);
    q0.push_back(model(1'b1, b2b_w[k], b2b_a[k], b2b_d[k], b2b_idx[k]));
    drive(b2b_w[k], b2b_a[k], b2b_d[k], b2b_idx[k]);
  endtask

  task automatic test_back_to_back;
    int resp = 0, last = -1, gap_bad = 0, k = 0;
    b2b_w[0] = 1; b2b_a[0] = 32'h40; b2b_d[0] = 32'h11111111; b2b_idx[0] = 3'b010;
    b2b_w[1] = 1; b2b_a[1] = 32'h45; b2b_d[1] = 32'h00000022; b2b_idx[1] = 3'b000;
    b2b_w[2] = 1; b2b_a[2] = 32'h46; b2b_d[2] = 32'h00003344; b2b_idx[2] = 3'b001;
    b2b_w[3] = 1; b2b_a[3] = 32'h44; b2b_d[3] = 32'h0000009C; b2b_idx[3] = 3'b000;
    b2b_w[4] = 0; b2b_a[4] = 32'h40; b2b_d[4] = 32'h0;        b2b_idx[4] = 3'b010;
    b2b_w[5] = 0; b2b_a[5] = 32'h44; b2b_d[5] = 32'h0;        b2b_idx[5] = 3'b010;
    b2b_w[6] = 0; b2b_a[6] = 32'h46; b2b_d[6] = 32'h0;        b2b_idx[6] = 3'b101;
    b2b_w[7] = 0; b2b_a[7] = 32'h44; b2b_d[7] = 32'h0;        b2b_idx[7] = 3'b000;
    @(posedge clk); #1;
    drive_op0(0);
    req0 = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (valid0) begin
        resp++;
        if (last >= 0 && c - last != 2) gap_bad++;
        if (stall0 !== 1'b0) gap_bad++;
        last = c;
        k++;
        if (k < 8) drive_op0(k);
        else req0 = 1'b0;
      end
    end
    req0 = 1'b0;
    n_checks++; if (resp !== 8)    begin n_fail++; $display("FAIL b2b_count: got %0d responses want 8", resp); end
    n_checks++; if (gap_bad !== 0) begin n_fail++; $display("FAIL b2b_spacing: %0d bad gaps want 0", gap_bad); end
  endtask

  initial begin
    rst_n = 1'b0; req1 = 1'b0; req0 = 1'b0; we = 1'b0;
    raddr = '0; waddr = '0; wdata = '0; ridx = '0; widx = '0;
    repeat (3) @(posedge clk);
    test_reset;
    @(posedge clk); #1;
    rst_n = 1'b1;
    test_word;
    test_byte_half;
    test_misalign;
    test_wrap;
    test_reset_abort;
    test_back_to_back;
    repeat (3) @(posedge clk);
    n_checks++; if (q1.size() != 0) begin n_fail++; $display("FAIL sb1_drain: %0d pending want 0", q1.size()); end
    n_checks++; if (q0.size() != 0) begin n_fail++; $display("FAIL sb0_drain: %0d pending want 0", q0.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
